// File: rtl/l2_mem_responder.sv
// Line-granular main-memory stand-in below the L2: arbitrates I/D ports, fixed LATENCY, 1-cycle ready pulse.
// Define L2_MEM_RESP_RR_EN for round-robin tie-breaking; otherwise the D-port always wins ties.
module l2_mem_responder #(
  parameter int LATENCY    = 4,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic         clk,
  input  logic         proc_reset,
  input  logic         memi_read,
  input  logic         memi_write,
  input  logic [27:0]  memi_addr,
  input  logic [127:0] memi_wdata,
  output logic [127:0] memi_rdata,
  output logic         memi_ready,
  input  logic         memd_read,
  input  logic         memd_write,
  input  logic [27:0]  memd_addr,
  input  logic [127:0] memd_wdata,
  output logic [127:0] memd_rdata,
  output logic         memd_ready
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state, state_nxt;
  logic [7:0]              cnt;
  logic                    req_i, req_d, req_any, grant_d, commit;
  logic                    cur_d, cur_wr;
  logic [DEPTH_LOG2-1:0]   cur_idx;
  logic [127:0]            cur_wdata;
  logic [127:0]            mem [0:(1<<DEPTH_LOG2)-1];

  // Upper address bits only select aliases of the same line.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{memi_addr[27:DEPTH_LOG2], memd_addr[27:DEPTH_LOG2]};

  assign req_i   = memi_read | memi_write;
  assign req_d   = memd_read | memd_write;
  assign req_any = req_i | req_d;

`ifdef L2_MEM_RESP_RR_EN
  logic rr_d_next;

  assign grant_d = req_d & (~req_i | rr_d_next);

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      rr_d_next <= 1'b0;
    end else if (state == IDLE && req_any) begin
      rr_d_next <= ~grant_d;
    end
  end
`else
  assign grant_d = req_d;
`endif

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    case (state)
      IDLE: if (req_any) state_nxt = WAIT;
      WAIT: begin
        if (cnt == 8'd0) begin
          commit    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request is captured at grant so later input changes cannot disturb it.
  always_ff @(posedge clk) begin
    if (state == IDLE && req_any) begin
      cur_d     <= grant_d;
      cur_wr    <= grant_d ? memd_write : memi_write;
      cur_idx   <= grant_d ? memd_addr[DEPTH_LOG2-1:0] : memi_addr[DEPTH_LOG2-1:0];
      cur_wdata <= grant_d ? memd_wdata : memi_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!proc_reset && commit && cur_wr) begin
      mem[cur_idx] <= cur_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      cnt        <= 8'd0;
      memi_ready <= 1'b0;
      memd_ready <= 1'b0;
      memi_rdata <= 128'd0;
      memd_rdata <= 128'd0;
    end else begin
      memi_ready <= commit & ~cur_d;
      memd_ready <= commit & cur_d;
      if (state == IDLE && req_any) begin
        cnt <= 8'(LATENCY - 1);
      end else if (state == WAIT && cnt != 8'd0) begin
        cnt <= cnt - 8'd1;
      end
      if (commit && !cur_wr) begin
        if (cur_d) begin
          memd_rdata <= mem[cur_idx];
        end else begin
          memi_rdata <= mem[cur_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_l2_mem_responder.sv
// Randomized bench for l2_mem_responder against a transaction-level memory/arbitration model.
module tb_l2_mem_responder;
  localparam int LAT = 4;
  localparam int DL  = 10;

  logic         clk = 1'b0;
  logic         proc_reset;
  logic         memi_read, memi_write, memd_read, memd_write;
  logic [27:0]  memi_addr, memd_addr;
  logic [127:0] memi_wdata, memd_wdata, memi_rdata, memd_rdata;
  logic         memi_ready, memd_ready;

  l2_mem_responder #(.LATENCY(LAT), .DEPTH_LOG2(DL)) dut (
    .clk(clk), .proc_reset(proc_reset),
    .memi_read(memi_read), .memi_write(memi_write), .memi_addr(memi_addr),
    .memi_wdata(memi_wdata), .memi_rdata(memi_rdata), .memi_ready(memi_ready),
    .memd_read(memd_read), .memd_write(memd_write), .memd_addr(memd_addr),
    .memd_wdata(memd_wdata), .memd_rdata(memd_rdata), .memd_ready(memd_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: line store, per-port last read line, last granted port.
  logic [127:0] ref_mem [0:(1<<DL)-1];
  logic [127:0] m_rd_i, m_rd_d;
  bit           m_last_d;

`ifdef L2_MEM_RESP_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [27:0] mk_addr(input int idx);
    logic [27:0] a;
    a = 28'($urandom);
    a[DL-1:0] = DL'(idx);
    return a;
  endfunction

  task automatic xact(input bit pd, input bit rd, input bit wr, input logic [27:0] a,
                      input logic [127:0] d, input int drop_at, output int rcyc);
    int n;
    bit got;
    @(posedge clk); #1;
    if (pd) begin
      memd_read = rd; memd_write = wr; memd_addr = a; memd_wdata = d;
    end else begin
      memi_read = rd; memi_write = wr; memi_addr = a; memi_wdata = d;
    end
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      got = pd ? memd_ready : memi_ready;
      if (n == drop_at) begin
        if (pd) begin
          memd_read = 0; memd_write = 0; memd_addr = 28'($urandom); memd_wdata = {4{$urandom}};
        end else begin
          memi_read = 0; memi_write = 0; memi_addr = 28'($urandom); memi_wdata = {4{$urandom}};
        end
      end
    end
    check("latency", 128'(n), 128'(LAT + 1));
    rcyc = cyc;
    memd_read = 0; memd_write = 0; memi_read = 0; memi_write = 0;
    if (wr) ref_mem[a[DL-1:0]] = d;
    else if (rd) begin
      if (pd) m_rd_d = ref_mem[a[DL-1:0]];
      else    m_rd_i = ref_mem[a[DL-1:0]];
    end
    m_last_d = pd;
    check("rdata_i", memi_rdata, m_rd_i);
    check("rdata_d", memd_rdata, m_rd_d);
  endtask

  // Both ports hold a read request until each has received its number of grants.
  task automatic race(input int ni, input int nd, input logic [27:0] ai, input logic [27:0] ad);
    bit exp_d [$];
    int ri, rd, n, k, gi, gd, tot;
    bit w, obs_d;
    ri = ni; rd = nd;
    while (ri > 0 || rd > 0) begin
      if (ri > 0 && rd > 0) w = RR ? !m_last_d : 1'b1;
      else w = (rd > 0);
      exp_d.push_back(w);
      m_last_d = w;
      if (w) rd--; else ri--;
    end
    tot = ni + nd;
    @(posedge clk); #1;
    memi_read = (ni > 0); memi_addr = ai;
    memd_read = (nd > 0); memd_addr = ad;
    n = 0; k = 0; gi = 0; gd = 0;
    while (k < tot && n < tot * (LAT + 2) + 10) begin
      @(posedge clk); #1;
      n++;
      if (memi_ready || memd_ready) begin
        obs_d = memd_ready;
        check("race_port", 128'(obs_d), 128'(exp_d[k]));
        check("race_cycle", 128'(n), 128'((LAT + 1) + k * (LAT + 2)));
        check("race_single", 128'(memi_ready & memd_ready), 128'(0));
        if (obs_d) begin
          m_rd_d = ref_mem[ad[DL-1:0]];
          check("race_rdata_d", memd_rdata, m_rd_d);
          gd++;
          if (gd >= nd) memd_read = 0;
        end else begin
          m_rd_i = ref_mem[ai[DL-1:0]];
          check("race_rdata_i", memi_rdata, m_rd_i);
          gi++;
          if (gi >= ni) memi_read = 0;
        end
        k++;
      end
    end
    check("race_done", 128'(k), 128'(tot));
    memi_read = 0; memd_read = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    proc_reset = 1;
    memi_read = 0; memi_write = 0; memd_read = 0; memd_write = 0;
    @(posedge clk); #1;
    check("rst_ready_i", 128'(memi_ready), 128'(0));
    check("rst_ready_d", 128'(memd_ready), 128'(0));
    check("rst_rdata_i", memi_rdata, 128'(0));
    check("rst_rdata_d", memd_rdata, 128'(0));
    proc_reset = 0;
    m_rd_i = 0; m_rd_d = 0; m_last_d = 1'b1;
  endtask

  logic [127:0] beef, old, fresh;
  int           c1, c2, seen;

  initial begin
    proc_reset = 1;
    memi_read = 0; memi_write = 0; memd_read = 0; memd_write = 0;
    memi_addr = 0; memd_addr = 0; memi_wdata = 0; memd_wdata = 0;
    repeat (2) @(posedge clk);
    do_reset();

    // Seed lines 0..31 so every later read has a known model value.
    for (int i = 0; i < 32; i++)
      xact(i[0], 1'b0, 1'b1, mk_addr(i), {$urandom, $urandom, $urandom, $urandom}, 0, c1);

    // Storage survives reset; tie arbitration starts from "I next".
    do_reset();
    race(1, 1, mk_addr(3), mk_addr(4));
    race(2, 2, mk_addr(5), mk_addr(6));

    // Write then read with long hold.
    beef = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
    xact(1'b1, 1'b0, 1'b1, 28'h000_0010, beef, 0, c1);
    @(posedge clk); #1;
    check("ready_pulse", 128'(memd_ready), 128'(0));
    xact(1'b1, 1'b1, 1'b0, 28'h000_0010, 128'd0, 0, c1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("rdata_hold", memd_rdata, beef);
    end

    // Aliasing.
    xact(1'b1, 1'b0, 1'b1, 28'h000_0400, ~beef, 0, c1);
    xact(1'b0, 1'b1, 1'b0, 28'h000_0000, 128'd0, 0, c1);
    check("alias", memi_rdata, ~beef);

    // Writeback then allocate, back to back on D.
    xact(1'b1, 1'b0, 1'b1, mk_addr(7), {4{32'hA5A5_0707}}, 0, c1);
    xact(1'b1, 1'b1, 1'b0, mk_addr(8), 128'd0, 0, c2);
    check("wb_alloc_gap", 128'(c2 - c1), 128'(LAT + 2));

    // Reset during WAIT of a write.
    old = ref_mem[9];
    fresh = ~old;
    @(posedge clk); #1;
    memd_write = 1; memd_addr = mk_addr(9); memd_wdata = fresh;
    repeat (3) @(posedge clk);
    #1;
    memd_write = 0;
    do_reset();
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (memi_ready || memd_ready) seen++;
    end
    check("rst_no_ready", 128'(seen), 128'(0));
    xact(1'b1, 1'b1, 1'b0, mk_addr(9), 128'd0, 0, c1);
    check("rst_old_data", memd_rdata, old);

    // Dropped request and read+write on one port.
    xact(1'b1, 1'b0, 1'b1, mk_addr(10), {4{32'h1234_5678}}, 2, c1);
    xact(1'b0, 1'b1, 1'b1, mk_addr(11), {4{32'h0BAD_F00D}}, 2, c1);
    xact(1'b1, 1'b1, 1'b0, mk_addr(11), 128'd0, 0, c1);

    // Random traffic.
    for (int t = 0; t < 40; t++) begin
      int r, op;
      r = $urandom_range(0, 9);
      if (r < 2) begin
        race($urandom_range(1, 2), $urandom_range(1, 2),
             mk_addr($urandom_range(0, 31)), mk_addr($urandom_range(0, 31)));
      end else begin
        op = $urandom_range(0, 2);
        xact(1'($urandom_range(0, 1)), op != 1, op != 0, mk_addr($urandom_range(0, 31)),
             {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 6), c1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
